// File: rtl/proc_alu_arbiter.sv
// Round-robin arbiter sharing one latency-insensitive ALU between two
// requesters. An in-order tag FIFO remembers which requester each in-flight
// request came from so the response can be steered back to it.
module proc_alu_arbiter #(
  parameter int unsigned TAG_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          req0_val,
  output logic          req0_rdy,
  input  logic [70:0]   req0_msg,

  input  logic          req1_val,
  output logic          req1_rdy,
  input  logic [70:0]   req1_msg,

  output logic          resp0_val,
  input  logic          resp0_rdy,
  output logic [34:0]   resp0_msg,

  output logic          resp1_val,
  input  logic          resp1_rdy,
  output logic [34:0]   resp1_msg,

  output logic          alu_req_val,
  input  logic          alu_req_rdy,
  output logic [70:0]   alu_req_msg,

  input  logic          alu_resp_val,
  output logic          alu_resp_rdy,
  input  logic [34:0]   alu_resp_msg,

  output logic          err
);

  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);
  localparam int unsigned TAG_N = 1 << PTR_W;

  logic               prio_q;
  logic [TAG_N-1:0]   tag_q;
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;

  logic               not_full;
  logic               empty;
  logic               grant0;
  logic               grant1;
  logic               head_id;
  logic               push;
  logic               pop;
  logic               spurious;

  // Wrap-around pointer increment for a FIFO that may not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(TAG_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign not_full = (count_q < CNT_W'(TAG_DEPTH));
  assign empty    = (count_q == '0);
  assign head_id  = tag_q[head_q];
  assign err      = err_q;

  // Round-robin grant selection; prio picks the winner only under contention.
  always_comb begin
    grant0 = req0_val && (!req1_val || !prio_q);
    grant1 = req1_val && (!req0_val ||  prio_q);
  end

  // Request path toward the ALU: gated by tag space, zeroed when idle.
  always_comb begin
    alu_req_val = 1'b0;
    alu_req_msg = '0;
    req0_rdy    = 1'b0;
    req1_rdy    = 1'b0;
    if (not_full && (req0_val || req1_val)) begin
      alu_req_val = 1'b1;
      alu_req_msg = grant1 ? req1_msg : req0_msg;
      req0_rdy    = alu_req_rdy && grant0;
      req1_rdy    = alu_req_rdy && grant1;
    end
  end

  // Response steering to the requester recorded at the FIFO head.
  always_comb begin
    resp0_val    = 1'b0;
    resp0_msg    = '0;
    resp1_val    = 1'b0;
    resp1_msg    = '0;
    // Must stay high when empty: the ALU couples input rdy to output rdy.
    alu_resp_rdy = 1'b1;
    if (!empty) begin
      if (head_id) begin
        resp1_val    = alu_resp_val;
        resp1_msg    = alu_resp_msg;
        alu_resp_rdy = resp1_rdy;
      end else begin
        resp0_val    = alu_resp_val;
        resp0_msg    = alu_resp_msg;
        alu_resp_rdy = resp0_rdy;
      end
    end
  end

  assign push     = alu_req_val && alu_req_rdy;
  assign pop      = alu_resp_val && alu_resp_rdy && !empty;
  assign spurious = alu_resp_val && empty;

  // Priority pointer, tag FIFO and sticky error state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q  <= 1'b0;
      tag_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        tag_q[tail_q] <= grant1;
        tail_q        <= ptr_inc(tail_q);
        prio_q        <= !grant1;
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (spurious) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_proc_alu_arbiter.sv
// Directed bench for proc_alu_arbiter: a depth-2 instance behind a 1-cycle
// ALU model and a depth-1 instance driven directly on its ALU side.
module tb_proc_alu_arbiter;

  logic clk;
  logic reset;

  // Depth-2 instance signals
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [70:0] req0_msg, req1_msg;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [34:0] resp0_msg, resp1_msg;
  logic        alu_req_val, alu_req_rdy;
  logic [70:0] alu_req_msg;
  logic        alu_resp_val, alu_resp_rdy;
  logic [34:0] alu_resp_msg;
  logic        err;

  // Depth-1 instance signals
  logic        b_req0_val, b_req0_rdy, b_req1_val, b_req1_rdy;
  logic [70:0] b_req0_msg, b_req1_msg;
  logic        b_resp0_val, b_resp0_rdy, b_resp1_val, b_resp1_rdy;
  logic [34:0] b_resp0_msg, b_resp1_msg;
  logic        b_alu_req_val, b_alu_req_rdy;
  logic [70:0] b_alu_req_msg;
  logic        b_alu_resp_val, b_alu_resp_rdy;
  logic [34:0] b_alu_resp_msg;
  logic        b_err;

  // ALU model state and spurious-response injection
  logic        alu_v;
  logic [34:0] alu_d;
  logic        inj_val;
  logic [34:0] inj_msg;

  int vectors;
  int miscompares;

  proc_alu_arbiter #(.TAG_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .alu_req_val(alu_req_val), .alu_req_rdy(alu_req_rdy), .alu_req_msg(alu_req_msg),
    .alu_resp_val(alu_resp_val), .alu_resp_rdy(alu_resp_rdy), .alu_resp_msg(alu_resp_msg),
    .err(err)
  );

  proc_alu_arbiter #(.TAG_DEPTH(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0_val(b_req0_val), .req0_rdy(b_req0_rdy), .req0_msg(b_req0_msg),
    .req1_val(b_req1_val), .req1_rdy(b_req1_rdy), .req1_msg(b_req1_msg),
    .resp0_val(b_resp0_val), .resp0_rdy(b_resp0_rdy), .resp0_msg(b_resp0_msg),
    .resp1_val(b_resp1_val), .resp1_rdy(b_resp1_rdy), .resp1_msg(b_resp1_msg),
    .alu_req_val(b_alu_req_val), .alu_req_rdy(b_alu_req_rdy), .alu_req_msg(b_alu_req_msg),
    .alu_resp_val(b_alu_resp_val), .alu_resp_rdy(b_alu_resp_rdy), .alu_resp_msg(b_alu_resp_msg),
    .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle ALU whose input rdy is coupled to its output rdy
  assign alu_req_rdy  = !alu_v || alu_resp_rdy;
  assign alu_resp_val = alu_v || inj_val;
  assign alu_resp_msg = alu_v ? alu_d : inj_msg;

  function automatic logic [34:0] alu_f(input logic [70:0] m);
    logic [31:0] a;
    logic [31:0] b;
    a = m[63:32];
    b = m[31:0];
    return {a == b, $signed(a) < $signed(b), a < b, a + b};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_v <= 1'b0;
      alu_d <= '0;
    end else if (alu_req_rdy) begin
      alu_v <= alu_req_val;
      alu_d <= alu_f(alu_req_msg);
    end
  end

  function automatic logic [70:0] mk(input logic [31:0] a, input logic [31:0] b);
    return {7'h00, a, b};
  endfunction

  function automatic logic [34:0] rsp(input logic eq, input logic lt, input logic ltu,
                                      input logic [31:0] o);
    return {eq, lt, ltu, o};
  endfunction

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
    resp0_rdy = 1; resp1_rdy = 1;
    inj_val = 0; inj_msg = '0;
    b_req0_val = 0; b_req1_val = 0; b_req0_msg = '0; b_req1_msg = '0;
    b_resp0_rdy = 1; b_resp1_rdy = 1;
    b_alu_req_rdy = 0; b_alu_resp_val = 0; b_alu_resp_msg = '0;

    // Reset state
    #2;
    chk("rst_alu_req_val", 71'(alu_req_val), 71'(1'b0));
    chk("rst_req0_rdy", 71'(req0_rdy), 71'(1'b0));
    chk("rst_resp0_val", 71'(resp0_val), 71'(1'b0));
    chk("rst_resp1_val", 71'(resp1_val), 71'(1'b0));
    chk("rst_alu_resp_rdy", 71'(alu_resp_rdy), 71'(1'b1));
    chk("rst_err", 71'(err), 71'(1'b0));
    #10 reset = 1'b0;

    // Single client: add 5 + 7
    tick;
    req0_val = 1; req0_msg = mk(32'd5, 32'd7);
    #1;
    chk("t1_req0_rdy", 71'(req0_rdy), 71'(1'b1));
    chk("t1_req1_rdy", 71'(req1_rdy), 71'(1'b0));
    chk("t1_alu_req_msg", alu_req_msg, mk(32'd5, 32'd7));
    tick;
    req0_val = 0;
    #1;
    chk("t1_resp0_val", 71'(resp0_val), 71'(1'b1));
    chk("t1_resp0_msg", 71'(resp0_msg), 71'(rsp(1'b0, 1'b1, 1'b1, 32'd12)));
    chk("t1_resp1_val", 71'(resp1_val), 71'(1'b0));
    chk("t1_idle_alu_req_msg", alu_req_msg, 71'd0);
    tick;
    #1;
    chk("t1_drained_resp0_val", 71'(resp0_val), 71'(1'b0));
    chk("t1_drained_alu_resp_rdy", 71'(alu_resp_rdy), 71'(1'b1));

    // Contention after a fresh reset: grants alternate 0,1,0,1,...
    reset = 1'b1;
    #2 reset = 1'b0;
    tick;
    for (int k = 0; k < 8; k++) begin
      req0_val = 1; req0_msg = mk(32'(100 + (k + 1) / 2), 32'd1);
      req1_val = 1; req1_msg = mk(32'(200 + k / 2), 32'd1);
      #1;
      chk("t2_req0_rdy", 71'(req0_rdy), 71'((k % 2) == 0));
      chk("t2_req1_rdy", 71'(req1_rdy), 71'((k % 2) == 1));
      if ((k % 2) == 0) chk("t2_alu_req_msg", alu_req_msg, mk(32'(100 + k / 2), 32'd1));
      else              chk("t2_alu_req_msg", alu_req_msg, mk(32'(200 + k / 2), 32'd1));
      if (k > 0) begin
        if (((k - 1) % 2) == 0) begin
          chk("t2_resp0_val", 71'(resp0_val), 71'(1'b1));
          chk("t2_resp1_val", 71'(resp1_val), 71'(1'b0));
          chk("t2_resp0_msg", 71'(resp0_msg), 71'(rsp(1'b0, 1'b0, 1'b0, 32'(101 + (k - 1) / 2))));
        end else begin
          chk("t2_resp1_val", 71'(resp1_val), 71'(1'b1));
          chk("t2_resp0_val", 71'(resp0_val), 71'(1'b0));
          chk("t2_resp1_msg", 71'(resp1_msg), 71'(rsp(1'b0, 1'b0, 1'b0, 32'(201 + (k - 1) / 2))));
        end
      end
      tick;
    end
    req0_val = 0; req1_val = 0;
    #1;
    chk("t2_last_resp1_val", 71'(resp1_val), 71'(1'b1));
    chk("t2_last_resp1_msg", 71'(resp1_msg), 71'(rsp(1'b0, 1'b0, 1'b0, 32'd204)));
    tick;

    // Backpressure on requester 1 response
    req1_val = 1; req1_msg = mk(32'd9, 32'd3);
    #1;
    chk("t3_issue_req1_rdy", 71'(req1_rdy), 71'(1'b1));
    tick;
    req1_val = 0; req0_val = 1; req0_msg = mk(32'd4, 32'd4); resp1_rdy = 0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t3_stall_resp1_val", 71'(resp1_val), 71'(1'b1));
      chk("t3_stall_alu_resp_rdy", 71'(alu_resp_rdy), 71'(1'b0));
      chk("t3_stall_req0_rdy", 71'(req0_rdy), 71'(1'b0));
      chk("t3_stall_resp0_val", 71'(resp0_val), 71'(1'b0));
      tick;
    end
    resp1_rdy = 1;
    #1;
    chk("t3_release_resp1_msg", 71'(resp1_msg), 71'(rsp(1'b0, 1'b0, 1'b0, 32'd12)));
    chk("t3_release_alu_resp_rdy", 71'(alu_resp_rdy), 71'(1'b1));
    chk("t3_release_req0_rdy", 71'(req0_rdy), 71'(1'b1));
    tick;
    req0_val = 0;
    #1;
    chk("t3_after_resp0_val", 71'(resp0_val), 71'(1'b1));
    chk("t3_after_resp0_msg", 71'(resp0_msg), 71'(rsp(1'b1, 1'b0, 1'b0, 32'd8)));
    chk("t3_after_resp1_val", 71'(resp1_val), 71'(1'b0));
    tick;

    // Full FIFO on the depth-1 instance
    b_req0_val = 1; b_req0_msg = mk(32'd3, 32'd3); b_alu_req_rdy = 1;
    #1;
    chk("t4_first_req0_rdy", 71'(b_req0_rdy), 71'(1'b1));
    tick;
    #1;
    chk("t4_full_req0_rdy", 71'(b_req0_rdy), 71'(1'b0));
    chk("t4_full_alu_req_val", 71'(b_alu_req_val), 71'(1'b0));
    tick;
    #1;
    chk("t4_full2_req0_rdy", 71'(b_req0_rdy), 71'(1'b0));
    b_alu_resp_val = 1; b_alu_resp_msg = rsp(1'b1, 1'b0, 1'b0, 32'd6);
    #1;
    chk("t4_pop_resp0_val", 71'(b_resp0_val), 71'(1'b1));
    chk("t4_pop_resp0_msg", 71'(b_resp0_msg), 71'(rsp(1'b1, 1'b0, 1'b0, 32'd6)));
    chk("t4_pop_alu_resp_rdy", 71'(b_alu_resp_rdy), 71'(1'b1));
    chk("t4_no_bypass_req0_rdy", 71'(b_req0_rdy), 71'(1'b0));
    tick;
    b_alu_resp_val = 0;
    #1;
    chk("t4_freed_req0_rdy", 71'(b_req0_rdy), 71'(1'b1));
    chk("t4_freed_resp0_val", 71'(b_resp0_val), 71'(1'b0));
    b_req0_val = 0;
    tick;

    // Spurious response with empty FIFO
    inj_val = 1; inj_msg = 35'h1234;
    #1;
    chk("t5_resp0_val", 71'(resp0_val), 71'(1'b0));
    chk("t5_resp1_val", 71'(resp1_val), 71'(1'b0));
    chk("t5_alu_resp_rdy", 71'(alu_resp_rdy), 71'(1'b1));
    chk("t5_err_before", 71'(err), 71'(1'b0));
    tick;
    inj_val = 0;
    #1;
    chk("t5_err_set", 71'(err), 71'(1'b1));
    tick;
    #1;
    chk("t5_err_held", 71'(err), 71'(1'b1));

    // Reset mid-flight with one tag pending
    req0_val = 1; req0_msg = mk(32'd1, 32'd2); resp0_rdy = 0;
    #1;
    chk("t6_issue_req0_rdy", 71'(req0_rdy), 71'(1'b1));
    tick;
    req0_val = 0;
    #1;
    chk("t6_pending_resp0_val", 71'(resp0_val), 71'(1'b1));
    chk("t6_pending_alu_resp_rdy", 71'(alu_resp_rdy), 71'(1'b0));
    reset = 1'b1;
    #1;
    chk("t6_rst_alu_resp_rdy", 71'(alu_resp_rdy), 71'(1'b1));
    chk("t6_rst_err", 71'(err), 71'(1'b0));
    chk("t6_rst_resp0_val", 71'(resp0_val), 71'(1'b0));
    #1 reset = 1'b0;
    resp0_rdy = 1;
    req1_val = 1; req1_msg = mk(32'd6, 32'd6);
    #1;
    chk("t6_req1_rdy", 71'(req1_rdy), 71'(1'b1));
    chk("t6_req0_rdy", 71'(req0_rdy), 71'(1'b0));
    chk("t6_alu_req_msg", alu_req_msg, mk(32'd6, 32'd6));
    tick;
    req1_val = 0;
    #1;
    chk("t6_resp1_val", 71'(resp1_val), 71'(1'b1));
    chk("t6_resp1_msg", 71'(resp1_msg), 71'(rsp(1'b1, 1'b0, 1'b0, 32'd12)));
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
